ex_hazard_ctrl: RTL and testbench

- Pipeline hazard controller that sequences the EXECUTE stage.
- Generates the registered forwarding selects FA/FB consumed by EXECUTE, detects load-use hazards and stalls IF/ID while bubbling ID/EX, and squashes younger stages on a taken branch.
- Sits beside the ID/EX pipeline register; its select registers advance in lockstep with ID/EX.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/ex_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// EXECUTE hazard sequencer: registered forwarding selects (1-cycle, aligned with ID/EX), load-use stall/bubble, branch flush.
// No handshake; op_stall holds PC and IF/ID, op_bubble/op_flush squash the younger stages.
module ex_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 16,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] ip_rs_ID,
    input  logic [REG_W-1:0] ip_rt_ID,
    input  logic             ip_uses_rs_ID,
    input  logic             ip_uses_rt_ID,
    input  logic [REG_W-1:0] ip_dest_EX,
    input  logic             ip_RegWrite_EX,
    input  logic             ip_read_en_EX,
    input  logic [REG_W-1:0] ip_dest_MEM,
    input  logic             ip_RegWrite_MEM,
    input  logic             ip_branch_taken,
    output logic [1:0]       op_FA,
    output logic [1:0]       op_FB,
    output logic             op_stall,
    output logic             op_bubble,
    output logic             op_flush,
    output logic [CNT_W-1:0] op_stall_count,
    output logic [CNT_W-1:0] op_flush_count
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [1:0]       SEL_MEM = 2'b10;
    localparam logic [1:0]       SEL_WB  = 2'b01;
    localparam logic [1:0]       SEL_RF  = 2'b00;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]       STALL_LOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, cnt_nxt;

    logic       match_ex_rs, match_ex_rt, match_mem_rs, match_mem_rt;
    logic       haz;
    logic [1:0] fa_nxt, fb_nxt;

    // Register 0 is hardwired, so it never matches a producer.
    assign match_ex_rs  = ip_RegWrite_EX  && (ip_dest_EX  == ip_rs_ID) && (ip_rs_ID != '0);
    assign match_ex_rt  = ip_RegWrite_EX  && (ip_dest_EX  == ip_rt_ID) && (ip_rt_ID != '0);
    assign match_mem_rs = ip_RegWrite_MEM && (ip_dest_MEM == ip_rs_ID) && (ip_rs_ID != '0);
    assign match_mem_rt = ip_RegWrite_MEM && (ip_dest_MEM == ip_rt_ID) && (ip_rt_ID != '0);

    assign haz = ip_read_en_EX &&
                 ((ip_uses_rs_ID && match_ex_rs) || (ip_uses_rt_ID && match_ex_rt));

    always_comb begin
        fa_nxt = SEL_RF;
        fb_nxt = SEL_RF;
        if (ip_uses_rs_ID) begin
            if (match_ex_rs && !ip_read_en_EX) fa_nxt = SEL_MEM;
            else if (match_mem_rs)             fa_nxt = SEL_WB;
        end
        if (ip_uses_rt_ID) begin
            if (match_ex_rt && !ip_read_en_EX) fb_nxt = SEL_MEM;
            else if (match_mem_rt)             fb_nxt = SEL_WB;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_stall  = 1'b0;
        op_bubble = 1'b0;
        op_flush  = 1'b0;
        if (ip_branch_taken) begin
            // A taken branch overrides any stall and (re)starts the flush window.
            op_flush  = 1'b1;
            op_bubble = (state == FLUSH);
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FLUSH_LOAD;
            end else begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        end else begin
            case (state)
                RUN: begin
                    op_stall  = haz;
                    op_bubble = haz;
                    if (haz && (LOAD_STALL > 1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = STALL_LOAD;
                    end
                end
                STALL: begin
                    op_stall  = 1'b1;
                    op_bubble = 1'b1;
                    cnt_nxt   = cnt - 3'd1;
                    if (cnt_nxt == 3'd0) state_nxt = RUN;
                end
                FLUSH: begin
                    op_flush  = 1'b1;
                    op_bubble = 1'b1;
                    cnt_nxt   = cnt - 3'd1;
                    if (cnt_nxt == 3'd0) state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Selects describe the instruction entering EX on this edge; bubbles carry none.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_FA <= SEL_RF;
            op_FB <= SEL_RF;
        end else if (op_flush || op_bubble || op_stall) begin
            op_FA <= SEL_RF;
            op_FB <= SEL_RF;
        end else begin
            op_FA <= fa_nxt;
            op_FB <= fb_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_stall_count <= '0;
            op_flush_count <= '0;
        end else begin
            if (op_stall && (op_stall_count != '1))
                op_stall_count <= op_stall_count + CNT_ONE;
            if (ip_branch_taken && (op_flush_count != '1))
                op_flush_count <= op_flush_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench: instance a uses LOAD_STALL=1/CNT_W=16, instance b uses LOAD_STALL=3/CNT_W=4.
module tb_ex_hazard_ctrl;

    logic       clock;
    logic       reset;
    logic [4:0] rs, rt, dest_ex, dest_mem;
    logic       uses_rs, uses_rt, regwr_ex, rden_ex, regwr_mem, br;

    logic [1:0]  a_fa, a_fb, b_fa, b_fb;
    logic        a_stall, a_bubble, a_flush, b_stall, b_bubble, b_flush;
    logic [15:0] a_scnt, a_fcnt;
    logic [3:0]  b_scnt, b_fcnt;

    int vectors;
    int miscompares;

    ex_hazard_ctrl #(.REG_W(5), .CNT_W(16), .LOAD_STALL(1), .FLUSH_CYCLES(2)) u_a (
        .clock(clock), .reset(reset),
        .ip_rs_ID(rs), .ip_rt_ID(rt), .ip_uses_rs_ID(uses_rs), .ip_uses_rt_ID(uses_rt),
        .ip_dest_EX(dest_ex), .ip_RegWrite_EX(regwr_ex), .ip_read_en_EX(rden_ex),
        .ip_dest_MEM(dest_mem), .ip_RegWrite_MEM(regwr_mem), .ip_branch_taken(br),
        .op_FA(a_fa), .op_FB(a_fb), .op_stall(a_stall), .op_bubble(a_bubble), .op_flush(a_flush),
        .op_stall_count(a_scnt), .op_flush_count(a_fcnt)
    );

    ex_hazard_ctrl #(.REG_W(5), .CNT_W(4), .LOAD_STALL(3), .FLUSH_CYCLES(2)) u_b (
        .clock(clock), .reset(reset),
        .ip_rs_ID(rs), .ip_rt_ID(rt), .ip_uses_rs_ID(uses_rs), .ip_uses_rt_ID(uses_rt),
        .ip_dest_EX(dest_ex), .ip_RegWrite_EX(regwr_ex), .ip_read_en_EX(rden_ex),
        .ip_dest_MEM(dest_mem), .ip_RegWrite_MEM(regwr_mem), .ip_branch_taken(br),
        .op_FA(b_fa), .op_FB(b_fb), .op_stall(b_stall), .op_bubble(b_bubble), .op_flush(b_flush),
        .op_stall_count(b_scnt), .op_flush_count(b_fcnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs = 5'd0; rt = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
        dest_ex = 5'd0; regwr_ex = 1'b0; rden_ex = 1'b0;
        dest_mem = 5'd0; regwr_mem = 1'b0; br = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic load_use_rt2();
        idle();
        dest_ex = 5'd2; regwr_ex = 1'b1; rden_ex = 1'b1;
        rt = 5'd2; uses_rt = 1'b1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle();
        reset = 1'b0;
        #2;
        chk("rst_fa",    32'(a_fa), 32'd0);
        chk("rst_fb",    32'(a_fb), 32'd0);
        chk("rst_stall", 32'(a_stall), 32'd0);
        chk("rst_flush", 32'(b_flush), 32'd0);
        chk("rst_scnt",  32'(a_scnt), 32'd0);
        tick();
        reset = 1'b1;

        // add $3 in EX, sub $4,$3,$3 in ID
        idle();
        dest_ex = 5'd3; regwr_ex = 1'b1; rs = 5'd3; rt = 5'd3; uses_rs = 1'b1; uses_rt = 1'b1;
        settle();
        chk("alu_nostall", 32'(a_stall), 32'd0);
        tick();
        chk("alu_fa", 32'(a_fa), 32'b10);
        chk("alu_fb", 32'(a_fb), 32'b10);

        // EX and MEM both write $5: EX wins; then MEM only
        idle();
        dest_ex = 5'd5; regwr_ex = 1'b1; dest_mem = 5'd5; regwr_mem = 1'b1;
        rs = 5'd5; uses_rs = 1'b1;
        settle();
        tick();
        chk("prio_fa", 32'(a_fa), 32'b10);
        chk("prio_fb", 32'(a_fb), 32'b00);
        regwr_ex = 1'b0;
        settle();
        tick();
        chk("mem_fa", 32'(a_fa), 32'b01);

        // lw $2 in EX, ID reads $2 on rt, single stall cycle
        do_reset();
        load_use_rt2();
        settle();
        chk("lu_stall",  32'(a_stall), 32'd1);
        chk("lu_bubble", 32'(a_bubble), 32'd1);
        tick();
        chk("lu_fb_bub", 32'(a_fb), 32'b00);
        idle();
        dest_mem = 5'd2; regwr_mem = 1'b1; rt = 5'd2; uses_rt = 1'b1;
        settle();
        chk("lu_release", 32'(a_stall), 32'd0);
        tick();
        chk("lu_fb_wb", 32'(a_fb), 32'b01);
        chk("lu_scnt",  32'(a_scnt), 32'd1);

        // three-cycle stall aborted by a branch in the second STALL-state cycle
        do_reset();
        load_use_rt2();
        settle();
        chk("b_stall1", 32'(b_stall), 32'd1);
        tick();
        settle();
        chk("b_stall2", 32'(b_stall), 32'd1);
        tick();
        br = 1'b1;
        settle();
        chk("b_br_nostall", 32'(b_stall), 32'd0);
        chk("b_br_flush",   32'(b_flush), 32'd1);
        tick();
        chk("b_fcnt", 32'(b_fcnt), 32'd1);
        chk("b_scnt", 32'(b_scnt), 32'd2);
        chk("b_fb_flush", 32'(b_fb), 32'b00);
        idle();
        settle();
        chk("b_flush2",  32'(b_flush), 32'd1);
        chk("b_bubble2", 32'(b_bubble), 32'd1);
        tick();
        settle();
        chk("b_flush_end", 32'(b_flush), 32'd0);

        // $0 never forwards or stalls; uses_rt=0 suppresses an rt match
        do_reset();
        rs = 5'd0; uses_rs = 1'b1; dest_ex = 5'd0; regwr_ex = 1'b1; rden_ex = 1'b1;
        rt = 5'd7; uses_rt = 1'b0; dest_mem = 5'd7; regwr_mem = 1'b1;
        settle();
        chk("r0_a_stall", 32'(a_stall), 32'd0);
        chk("r0_b_stall", 32'(b_stall), 32'd0);
        tick();
        chk("r0_fa",    32'(a_fa), 32'b00);
        chk("nouse_fb", 32'(a_fb), 32'b00);

        // reset asserted mid-FLUSH
        do_reset();
        br = 1'b1;
        settle();
        chk("fl_taken", 32'(a_flush), 32'd1);
        tick();
        br = 1'b0;
        settle();
        chk("fl_hold", 32'(a_flush), 32'd1);
        chk("fl_fcnt", 32'(a_fcnt), 32'd1);
        reset = 1'b0;
        #1;
        chk("fl_rst_flush", 32'(a_flush), 32'd0);
        chk("fl_rst_fcnt",  32'(a_fcnt), 32'd0);
        chk("fl_rst_fa",    32'(a_fa), 32'd0);
        chk("fl_rst_fb",    32'(a_fb), 32'd0);
        reset = 1'b1;

        // 2^4+5 consecutive stall cycles saturate the 4-bit counter
        tick();
        load_use_rt2();
        repeat (21) tick();
        settle();
        chk("sat_b_stall", 32'(b_stall), 32'd1);
        chk("sat_b_scnt",  32'(b_scnt), 32'hF);
        chk("sat_a_scnt",  32'(a_scnt), 32'd21);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
